// File: rtl/cop0_exception_controller_pkg.sv
// Shared constants for the COP0 exception controller: ExcCode values, FSM state encodings, ON/OFF levels.
// Pure declarations, no logic or latency.
// No flow control.
package cop0_exception_controller_pkg;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

  // MIPS Cause.ExcCode values handled by this controller
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Bit positions of the synchronous exception request vector
  localparam int REQ_ADEL = 0;
  localparam int REQ_ADES = 1;
  localparam int REQ_RI   = 2;
  localparam int REQ_OV   = 3;
  localparam int REQ_SYS  = 4;
  localparam int REQ_BP   = 5;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DRAIN    = 3'd1,
    ST_COMMIT   = 3'd2,
    ST_ERET     = 3'd3,
    ST_REDIRECT = 3'd4
  } state_t;

  // What the current sequence was started by; selects the redirect target and the statistics counter
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_EXC  = 2'd1,
    SRC_INT  = 2'd2,
    SRC_ERET = 2'd3
  } src_t;

endpackage

// File: rtl/cop0_exception_controller_priority_enc.sv
// Picks the highest-priority synchronous exception and returns its ExcCode.
// Purely combinational, zero latency.
// No flow control; the caller decides when the result is sampled.
module cop0_exc_priority_enc
  import cop0_exception_controller_pkg::*;
(
  input  logic [5:0] iExcReq,
  output logic       oValid,
  output logic [4:0] oCode
);

  // Fixed priority: AdEL > RI > Ov > Sys > Bp > AdES (AdES is last because a store
  // address fault is only detected late, after the others have had their chance)
  always_comb begin
    oValid = |iExcReq;
    oCode  = EXC_INT;
    if (iExcReq[REQ_ADEL])     oCode = EXC_ADEL;
    else if (iExcReq[REQ_RI])  oCode = EXC_RI;
    else if (iExcReq[REQ_OV])  oCode = EXC_OV;
    else if (iExcReq[REQ_SYS]) oCode = EXC_SYS;
    else if (iExcReq[REQ_BP])  oCode = EXC_BP;
    else if (iExcReq[REQ_ADES]) oCode = EXC_ADES;
  end

endmodule

// File: rtl/cop0_exception_controller.sv
// Sequences exception/interrupt entry and ERET exit around COP0; optional statistics under COP0_EXC_STATS_EN.
// Latency request->oPCWrite: DRAIN_CYCLES+2 cycles (exception/interrupt), 2 cycles (ERET).
// Stalls the pipeline while busy; requests are level-held by requesters and only sampled in IDLE.
module cop0_exception_controller
  import cop0_exception_controller_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180,
  parameter int          DRAIN_CYCLES = 2,
  parameter int          CNT_W        = 16
) (
  input  logic              iCLK,
  input  logic              iCLR,
  input  logic [5:0]        iExcReq,
  input  logic [31:0]       iExcPC,
  input  logic              iExcBD,
  input  logic [7:0]        iInterruptMask,
  input  logic              iExcLevel,
  input  logic              iEretReq,
  input  logic [31:0]       iEpcTarget,
  output logic              oStall,
  output logic              oFlush,
  output logic              oExcOccurred,
  output logic [4:0]        oExcCode,
  output logic              oBranchDelay,
  output logic [31:0]       oEPC,
  output logic              oEret,
  output logic              oPCWrite,
  output logic [31:0]       oPCTarget,
  output logic              oBusy
`ifdef COP0_EXC_STATS_EN
  ,
  output logic [CNT_W-1:0]  oExcCount,
  output logic [CNT_W-1:0]  oIntCount,
  output logic [4:0]        oLastCode
`endif
);

  if (DRAIN_CYCLES < 0 || DRAIN_CYCLES > 15 || CNT_W < 1) begin : gBadParams
    $error("cop0_exception_controller: DRAIN_CYCLES must be 0..15 and CNT_W >= 1");
  end

  // With no drain the flush moves into COMMIT so in-flight work is still squashed
  localparam bit         HAS_DRAIN  = (DRAIN_CYCLES > 0);
  localparam logic [3:0] DRAIN_LAST = 4'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  state_t      state, stateNxt;
  src_t        srcQ, srcNxt;
  logic [3:0]  drainCnt, drainNxt;
  logic [4:0]  codeQ, codeNxt;
  logic [31:0] epcQ, epcNxt;
  logic        bdQ, bdNxt;
  logic [31:0] eretTgtQ, eretTgtNxt;

  logic        syncValid;
  logic [4:0]  syncCode;
  logic        intReq;

  cop0_exc_priority_enc uPrioEnc (
    .iExcReq (iExcReq),
    .oValid  (syncValid),
    .oCode   (syncCode)
  );

  // Interrupts are masked while already at exception level; sync exceptions are not (nested entry)
  assign intReq = (|iInterruptMask) && !iExcLevel;

  // State and latched-context registers; reset aborts any sequence in flight
  always_ff @(posedge iCLK) begin
    if (!iCLR) begin
      state    <= ST_IDLE;
      srcQ     <= SRC_NONE;
      drainCnt <= 4'd0;
      codeQ    <= 5'd0;
      epcQ     <= 32'd0;
      bdQ      <= 1'b0;
      eretTgtQ <= 32'd0;
    end else begin
      state    <= stateNxt;
      srcQ     <= srcNxt;
      drainCnt <= drainNxt;
      codeQ    <= codeNxt;
      epcQ     <= epcNxt;
      bdQ      <= bdNxt;
      eretTgtQ <= eretTgtNxt;
    end
  end

  // Next-state, context capture and Moore outputs
  always_comb begin
    stateNxt     = state;
    srcNxt       = srcQ;
    drainNxt     = drainCnt;
    codeNxt      = codeQ;
    epcNxt       = epcQ;
    bdNxt        = bdQ;
    eretTgtNxt   = eretTgtQ;
    oFlush       = OFF;
    oExcOccurred = OFF;
    oExcCode     = 5'd0;
    oBranchDelay = OFF;
    oEPC         = 32'd0;
    oEret        = OFF;
    oPCWrite     = OFF;
    oPCTarget    = 32'd0;
    oStall       = (state != ST_IDLE);
    oBusy        = (state != ST_IDLE);

    case (state)
      ST_IDLE: begin
        // Arbitration: sync exception > ERET > interrupt; a losing ERET stays asserted and is retried
        if (syncValid) begin
          codeNxt  = syncCode;
          epcNxt   = iExcPC;
          bdNxt    = iExcBD;
          srcNxt   = SRC_EXC;
          drainNxt = 4'd0;
          stateNxt = HAS_DRAIN ? ST_DRAIN : ST_COMMIT;
        end else if (iEretReq) begin
          srcNxt   = SRC_ERET;
          stateNxt = ST_ERET;
        end else if (intReq) begin
          codeNxt  = EXC_INT;
          epcNxt   = iExcPC;
          bdNxt    = iExcBD;
          srcNxt   = SRC_INT;
          drainNxt = 4'd0;
          stateNxt = HAS_DRAIN ? ST_DRAIN : ST_COMMIT;
        end
      end
      ST_DRAIN: begin
        oFlush   = (drainCnt == 4'd0);
        drainNxt = drainCnt + 4'd1;
        if (drainCnt == DRAIN_LAST) stateNxt = ST_COMMIT;
      end
      ST_COMMIT: begin
        oFlush       = HAS_DRAIN ? OFF : ON;
        oExcOccurred = ON;
        oExcCode     = codeQ;
        oBranchDelay = bdQ;
        oEPC         = epcQ;
        stateNxt     = ST_REDIRECT;
      end
      ST_ERET: begin
        // COP0 has already resolved EPC (+4 / BD) onto iEpcTarget by the end of this cycle
        oEret      = ON;
        eretTgtNxt = iEpcTarget;
        stateNxt   = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        oPCWrite  = ON;
        oPCTarget = (srcQ == SRC_ERET) ? eretTgtQ : EXC_VECTOR;
        stateNxt  = ST_IDLE;
      end
      default: stateNxt = ST_IDLE;
    endcase
  end

`ifdef COP0_EXC_STATS_EN
  // Saturating commit counters split by source, plus the last committed code
  always_ff @(posedge iCLK) begin
    if (!iCLR) begin
      oExcCount <= '0;
      oIntCount <= '0;
      oLastCode <= 5'd0;
    end else if (state == ST_COMMIT) begin
      oLastCode <= codeQ;
      if (srcQ == SRC_INT) begin
        if (oIntCount != '1) oIntCount <= oIntCount + CNT_W'(1);
      end else begin
        if (oExcCount != '1) oExcCount <= oExcCount + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_cop0_exception_controller.sv
// Scoreboard bench: stimulus pushes expected pulse events, per-DUT monitors pop and compare.
// Instance A uses DRAIN_CYCLES=2, instance B uses DRAIN_CYCLES=0.
// Outputs are sampled on the falling edge.
module tb_cop0_exception_controller;

  typedef struct packed {
    int          cyc;
    logic [2:0]  kind;   // 1 flush, 2 exc strobe, 3 eret strobe, 4 pc write
    logic [4:0]  code;
    logic [31:0] epc;
    logic        bd;
    logic [31:0] tgt;
  } ev_t;

  localparam logic [31:0] VEC = 32'h8000_0180;

  logic        iCLK = 1'b0;
  logic        iCLR;
  logic [5:0]  excReq, bExcReq;
  logic [31:0] excPC, epcTarget;
  logic        excBD, excLevel, eretReq;
  logic [7:0]  intMask, bIntMask;

  logic        aStall, aFlush, aExc, aBD, aEret, aPCW, aBusy;
  logic [4:0]  aCode;
  logic [31:0] aEPC, aTgt;
  logic        bStall, bFlush, bExc, bBD, bEret, bPCW, bBusy;
  logic [4:0]  bCode;
  logic [31:0] bEPC, bTgt;
`ifdef COP0_EXC_STATS_EN
  logic [15:0] aExcCnt, aIntCnt, bExcCnt, bIntCnt;
  logic [4:0]  aLast, bLast;
`endif

  ev_t qA[$];
  ev_t qB[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  aBusyRun = 0;
  int  aLastRun = 0;
  int  expExc = 0;
  int  expInt = 0;
  logic [4:0] expLast = 5'd0;

  always #5 iCLK = ~iCLK;
  always @(posedge iCLK) cyc <= cyc + 1;

  cop0_exception_controller #(.EXC_VECTOR(VEC), .DRAIN_CYCLES(2), .CNT_W(16)) dutA (
    .iCLK(iCLK), .iCLR(iCLR), .iExcReq(excReq), .iExcPC(excPC), .iExcBD(excBD),
    .iInterruptMask(intMask), .iExcLevel(excLevel), .iEretReq(eretReq), .iEpcTarget(epcTarget),
    .oStall(aStall), .oFlush(aFlush), .oExcOccurred(aExc), .oExcCode(aCode), .oBranchDelay(aBD),
    .oEPC(aEPC), .oEret(aEret), .oPCWrite(aPCW), .oPCTarget(aTgt), .oBusy(aBusy)
`ifdef COP0_EXC_STATS_EN
    , .oExcCount(aExcCnt), .oIntCount(aIntCnt), .oLastCode(aLast)
`endif
  );

  cop0_exception_controller #(.EXC_VECTOR(VEC), .DRAIN_CYCLES(0), .CNT_W(16)) dutB (
    .iCLK(iCLK), .iCLR(iCLR), .iExcReq(bExcReq), .iExcPC(excPC), .iExcBD(excBD),
    .iInterruptMask(bIntMask), .iExcLevel(excLevel), .iEretReq(1'b0), .iEpcTarget(epcTarget),
    .oStall(bStall), .oFlush(bFlush), .oExcOccurred(bExc), .oExcCode(bCode), .oBranchDelay(bBD),
    .oEPC(bEPC), .oEret(bEret), .oPCWrite(bPCW), .oPCTarget(bTgt), .oBusy(bBusy)
`ifdef COP0_EXC_STATS_EN
    , .oExcCount(bExcCnt), .oIntCount(bIntCnt), .oLastCode(bLast)
`endif
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic cmpEv(input int which, input ev_t got);
    ev_t exp;
    checks++;
    if ((which == 0 && qA.size() == 0) || (which == 1 && qB.size() == 0)) begin
      errors++;
      $display("FAIL unexpected_event dut%0d: got kind %0d at cycle %0d, required none", which, got.kind, got.cyc);
      return;
    end
    if (which == 0) exp = qA.pop_front();
    else exp = qB.pop_front();
    if (got !== exp) begin
      errors++;
      $display("FAIL event dut%0d: got cyc=%0d kind=%0d code=%0d epc=%h bd=%b tgt=%h, required cyc=%0d kind=%0d code=%0d epc=%h bd=%b tgt=%h",
               which, got.cyc, got.kind, got.code, got.epc, got.bd, got.tgt,
               exp.cyc, exp.kind, exp.code, exp.epc, exp.bd, exp.tgt);
    end
  endtask

  task automatic monitor(input int which, input logic fl, input logic ex, input logic [4:0] code,
                         input logic [31:0] epc, input logic bd, input logic er, input logic pw,
                         input logic [31:0] tgt, input logic st, input logic bs);
    ev_t g;
    if (fl) begin g = '{cyc, 3'd1, 5'd0, 32'd0, 1'b0, 32'd0}; cmpEv(which, g); end
    if (ex) begin g = '{cyc, 3'd2, code, epc, bd, 32'd0};     cmpEv(which, g); end
    if (er) begin g = '{cyc, 3'd3, 5'd0, 32'd0, 1'b0, 32'd0}; cmpEv(which, g); end
    if (pw) begin g = '{cyc, 3'd4, 5'd0, 32'd0, 1'b0, tgt};   cmpEv(which, g); end
    checks++;
    if (st !== bs || (!ex && (code !== 5'd0 || epc !== 32'd0 || bd !== 1'b0)) || (!pw && tgt !== 32'd0)) begin
      errors++;
      $display("FAIL quiet dut%0d cycle %0d: stall=%b busy=%b code=%0d epc=%h bd=%b tgt=%h, required stall==busy and zero fields outside pulses",
               which, cyc, st, bs, code, epc, bd, tgt);
    end
  endtask

  always @(negedge iCLK) monitor(0, aFlush, aExc, aCode, aEPC, aBD, aEret, aPCW, aTgt, aStall, aBusy);
  always @(negedge iCLK) monitor(1, bFlush, bExc, bCode, bEPC, bBD, bEret, bPCW, bTgt, bStall, bBusy);

  always @(negedge iCLK) begin
    if (aBusy) aBusyRun++;
    else if (aBusyRun != 0) begin
      aLastRun = aBusyRun;
      aBusyRun = 0;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge iCLK);
    #1;
  endtask

  task automatic pushEv(input int which, input ev_t e);
    if (which == 0) qA.push_back(e);
    else qB.push_back(e);
  endtask

  // Request presented during cycle n: flush n+1, strobe n+1+D, redirect n+2+D
  task automatic pushExc(input int which, input int n, input logic [4:0] code, input logic [31:0] epc, input logic bd);
    int d;
    d = (which == 0) ? 2 : 0;
    pushEv(which, '{n + 1, 3'd1, 5'd0, 32'd0, 1'b0, 32'd0});
    pushEv(which, '{n + 1 + d, 3'd2, code, epc, bd, 32'd0});
    pushEv(which, '{n + 2 + d, 3'd4, 5'd0, 32'd0, 1'b0, VEC});
    if (which == 0) begin
      if (code == 5'd0) expInt++;
      else expExc++;
      expLast = code;
    end
  endtask

  task automatic pushEret(input int n, input logic [31:0] tgt);
    pushEv(0, '{n + 1, 3'd3, 5'd0, 32'd0, 1'b0, 32'd0});
    pushEv(0, '{n + 2, 3'd4, 5'd0, 32'd0, 1'b0, tgt});
  endtask

  task automatic waitIdle();
    int k;
    k = 0;
    while ((aBusy || bBusy) && k < 60) begin
      tick();
      k++;
    end
    checks++;
    if (k >= 60) begin
      errors++;
      $display("FAIL timeout: busy still high after %0d cycles, required idle", k);
    end
    tick(2);
  endtask

  typedef struct {
    logic [5:0] req;
    logic [4:0] code;
  } prio_t;

  prio_t prioTab[4] = '{
    '{6'b000011, 5'd4},   // AdEL beats AdES
    '{6'b100010, 5'd9},   // Bp beats AdES
    '{6'b110000, 5'd8},   // Sys beats Bp
    '{6'b000010, 5'd5}    // AdES alone, taken at exception level
  };

  initial begin
    int n;
    iCLR = 1'b0; excReq = '0; bExcReq = '0; excPC = '0; epcTarget = '0;
    excBD = 1'b0; excLevel = 1'b0; eretReq = 1'b0; intMask = '0; bIntMask = '0;
    tick(2);
    chk("rst_stall", {31'd0, aStall}, 32'd0);
    chk("rst_busy", {31'd0, aBusy}, 32'd0);
    chk("rst_flush", {31'd0, aFlush}, 32'd0);
    chk("rst_exc", {31'd0, aExc}, 32'd0);
    chk("rst_pcwrite", {31'd0, aPCW}, 32'd0);
    chk("rst_target", aTgt, 32'd0);
    chk("rst_epc", aEPC, 32'd0);
    chk("rst_code", {27'd0, aCode}, 32'd0);
    chk("rst_busy_b", {31'd0, bBusy}, 32'd0);
    iCLR = 1'b1;
    tick(2);

    // Overflow only
    excPC = 32'h0040_0010; excBD = 1'b0; excReq = 6'b001000;
    n = cyc; pushExc(0, n, 5'd12, 32'h0040_0010, 1'b0);
    tick(); excReq = '0;
    waitIdle();

    // Reset while draining: only the flush is seen, then everything clears
    excPC = 32'h0040_0020; excReq = 6'b001000;
    n = cyc; pushEv(0, '{n + 1, 3'd1, 5'd0, 32'd0, 1'b0, 32'd0});
    tick(); excReq = '0; iCLR = 1'b0;
    tick();
    chk("rst_mid_busy", {31'd0, aBusy}, 32'd0);
    chk("rst_mid_stall", {31'd0, aStall}, 32'd0);
    iCLR = 1'b1; expExc = 0; expInt = 0; expLast = 5'd0;
    tick(4);

    // RI+Ov+Bp held for several cycles: one entry, RI wins
    excPC = 32'h0040_0030; excBD = 1'b1; excReq = 6'b101100;
    n = cyc; pushExc(0, n, 5'd10, 32'h0040_0030, 1'b1);
    tick(4); excReq = '0;
    waitIdle(); tick(3);

    // Priority table
    for (int i = 0; i < 4; i++) begin
      excPC = 32'h0040_1000 + 32'(i * 4); excBD = i[0]; excLevel = (i == 3);
      excReq = prioTab[i].req;
      n = cyc; pushExc(0, n, prioTab[i].code, excPC, excBD);
      tick(); excReq = '0;
      waitIdle();
    end
    excLevel = 1'b0;

    // Interrupt blocked by exception level, then taken once it drops
    excPC = 32'h0040_0100; excBD = 1'b1; excLevel = 1'b1; intMask = 8'h01;
    tick(5);
    chk("int_masked_busy", {31'd0, aBusy}, 32'd0);
    excLevel = 1'b0;
    n = cyc; pushExc(0, n, 5'd0, 32'h0040_0100, 1'b1);
    tick(); intMask = '0;
    waitIdle();

    // ERET
    epcTarget = 32'h0040_0024; eretReq = 1'b1;
    n = cyc; pushEret(n, 32'h0040_0024);
    tick(); eretReq = 1'b0;
    waitIdle();
    chk("eret_busy_len", aLastRun, 32'd2);

    // Simultaneous Sys + ERET: exception first, ERET retried from the next IDLE cycle
    excPC = 32'h0040_0200; excBD = 1'b0; epcTarget = 32'h0040_0040;
    excReq = 6'b010000; eretReq = 1'b1;
    n = cyc; pushExc(0, n, 5'd8, 32'h0040_0200, 1'b0); pushEret(n + 5, 32'h0040_0040);
    tick(); excReq = '0;
    tick(5); eretReq = 1'b0;
    waitIdle();

    // Back-to-back: Bp held, second entry accepted in first IDLE cycle
    excPC = 32'h0040_0300; excReq = 6'b100000;
    n = cyc; pushExc(0, n, 5'd9, 32'h0040_0300, 1'b0); pushExc(0, n + 5, 5'd9, 32'h0040_0300, 1'b0);
    tick(6); excReq = '0;
    waitIdle();

    // Zero-drain instance: commit right after IDLE with flush in the same cycle
    excPC = 32'h0040_0010; excBD = 1'b0; bExcReq = 6'b001000;
    n = cyc; pushExc(1, n, 5'd12, 32'h0040_0010, 1'b0);
    tick(); bExcReq = '0;
    waitIdle();
    excPC = 32'h0040_0400; excBD = 1'b1; bIntMask = 8'h80;
    n = cyc; pushExc(1, n, 5'd0, 32'h0040_0400, 1'b1);
    tick(); bIntMask = '0;
    waitIdle();

    chk("queue_a_empty", qA.size(), 32'd0);
    chk("queue_b_empty", qB.size(), 32'd0);
`ifdef COP0_EXC_STATS_EN
    chk("stat_exc_count", {16'd0, aExcCnt}, expExc);
    chk("stat_int_count", {16'd0, aIntCnt}, expInt);
    chk("stat_last_code", {27'd0, aLast}, {27'd0, expLast});
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
